// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_pkg
//  Purpose  : Shared types and helpers for the bit-serial adder controller.
//             - state_e       : controller FSM encoding (2-bit)
//             - DEFAULT_WIDTH : default operand/result width
//             - full_add_ref  : 1-bit full-add reference returning {cout, s}
//  Revision : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Behavioural full add, independent of the gate-level bit cell.
    function automatic logic [1:0] full_add_ref(input logic a, input logic b, input logic cin);
        logic s;
        logic cout;
        s    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
        return {cout, s};
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_fa_bit.sv
`default_nettype none
// ============================================================================
//  Module   : serial_fa_bit
//  Purpose  : Combinational 1-bit full adder built from two cascaded
//             half-add stages; the two stage carries are ORed together.
//  Ports    : a, b   - operand bits
//             cin    - carry in
//             s      - sum bit
//             cout   - carry out
//  Revision : 1.0 - initial release
// ============================================================================
module serial_fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_p;   // first half-add sum (propagate)
    logic w_g0;  // first half-add carry (generate)
    logic w_g1;  // second half-add carry

    assign w_p  = a ^ b;
    assign w_g0 = a & b;

    assign s    = w_p ^ cin;
    assign w_g1 = w_p & cin;

    // Both stage carries can never be high together, so OR is exact.
    assign cout = w_g0 | w_g1;

endmodule
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_ctrl
//  Purpose  : Bit-serial adder controller. Accepts an operand pair over a
//             valid/ready handshake, adds it LSB-first through a single
//             1-bit full adder over WIDTH cycles, and presents
//             {carry_out, sum} on an output valid/ready handshake.
//  Ports    : clk, rst            - clock, asynchronous active-high reset
//             in_valid, in_ready  - operand handshake
//             a, b                - WIDTH-bit operands
//             out_valid, out_ready- result handshake
//             sum                 - a+b modulo 2^WIDTH
//             carry_out           - bit WIDTH of a+b
//  Revision : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [WIDTH-1:0]   r_sh_a;
    logic [WIDTH-1:0]   r_sh_b;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_s;
    logic               w_cout;

    assign w_accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Single shared bit cell: always looks at the current LSBs and carry.
    // ------------------------------------------------------------------
    serial_fa_bit u_fa (
        .a    (r_sh_a[0]),
        .b    (r_sh_b[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)             w_state_nxt = RUN;
            RUN:     if (r_cnt == c_CNT_LAST)  w_state_nxt = DONE;
            DONE:    if (out_ready)            w_state_nxt = IDLE;
            default:                           w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. in_ready is masked by rst so nothing is accepted while
    // the controller is held in reset.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE:    in_ready  = !rst;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Result registers only move on accept (clear) and in RUN, so they hold
    // through DONE and on into IDLE until the next accept.
    assign sum       = r_result;
    assign carry_out = r_carry;

    // ------------------------------------------------------------------
    // Datapath: operand shifters, result shifter, carry and bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_a   <= '0;
            r_sh_b   <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sh_a   <= a;
                        r_sh_b   <= b;
                        r_result <= '0;
                        r_carry  <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_sh_a   <= {1'b0, r_sh_a[WIDTH-1:1]};
                    r_sh_b   <= {1'b0, r_sh_b[WIDTH-1:1]};
                    // Sum bits enter at the MSB; after WIDTH shifts bit 0
                    // of the sum has arrived at result[0].
                    r_result <= {w_s, r_result[WIDTH-1:1]};
                    r_carry  <= w_cout;
                    r_cnt    <= r_cnt + c_CNT_ONE;
                end
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    // ------------------------------------------------------------------
    // Simulation-only checking: shadow operands and a cycles-since-accept
    // tracker, both cleared by reset so an aborted operation is forgotten.
    // The tracker reads 1 after the accepting edge and WIDTH+1 on the
    // cycle in which out_valid must first be seen.
    // ------------------------------------------------------------------
    localparam int               c_LAT_W    = CNT_W + 2;
    localparam logic [c_LAT_W-1:0] c_LAT_ONE  = c_LAT_W'(1);
    localparam logic [c_LAT_W-1:0] c_LAT_DONE = c_LAT_W'(WIDTH + 1);

    logic [WIDTH-1:0]   r_sim_a;
    logic [WIDTH-1:0]   r_sim_b;
    logic [c_LAT_W-1:0] r_sim_lat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sim_a   <= '0;
            r_sim_b   <= '0;
            r_sim_lat <= '0;
        end else begin
            if (w_accept) begin
                r_sim_a   <= a;
                r_sim_b   <= b;
                r_sim_lat <= c_LAT_ONE;
            end else if (r_sim_lat == c_LAT_DONE) begin
                r_sim_lat <= '0;
            end else if (r_sim_lat != '0) begin
                r_sim_lat <= r_sim_lat + c_LAT_ONE;
            end
        end
    end

    a_hold: assert property (@(posedge clk) disable iff (rst)
        out_valid && !out_ready |=> out_valid && $stable(sum) && $stable(carry_out))
        $display("sva a_hold: pass");
    else
        $display("sva a_hold: violated at %0t", $time);

    a_excl: assert property (@(posedge clk) disable iff (rst)
        !(in_ready && out_valid))
        $display("sva a_excl: pass");
    else
        $display("sva a_excl: violated at %0t", $time);

    a_latency: assert property (@(posedge clk) disable iff (rst)
        (r_sim_lat == c_LAT_DONE) |-> out_valid)
        $display("sva a_latency: pass");
    else
        $display("sva a_latency: violated at %0t", $time);

    a_not_early: assert property (@(posedge clk) disable iff (rst)
        (r_sim_lat != '0 && r_sim_lat != c_LAT_DONE) |-> !out_valid)
        $display("sva a_not_early: pass");
    else
        $display("sva a_not_early: violated at %0t", $time);

    a_result: assert property (@(posedge clk) disable iff (rst)
        $rose(out_valid) |-> ({carry_out, sum} == ({1'b0, r_sim_a} + {1'b0, r_sim_b})))
        $display("sva a_result: pass");
    else
        $display("sva a_result: violated at %0t", $time);
`endif

endmodule
`default_nettype wire
